// File: rtl/ps2_key_buffer.sv
// ==========================================================================
// Module  : ps2_key_buffer
// Purpose : Folds PS/2 E0/F0 prefixes into key events and queues them in a
//           first-word-fall-through FIFO that the processor pops.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module ps2_key_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_key_pressed,
  input  logic [7:0]        ps2_out,
  input  logic              rd_en,
  input  logic              clear_overflow,
  output logic              key_valid,
  output logic [31:0]       key_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [7:0]      c_ext_pfx = 8'hE0;
  localparam logic [7:0]      c_brk_pfx = 8'hF0;
  localparam logic [ADDR_W:0] c_depth   = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_push;
  logic [9:0]          w_push_data;
  logic                w_noise;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                w_ovf_set;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_nxt;
  logic                r_valid;
  logic                r_overflow;
  logic [9:0]          r_mem [DEPTH];

  // Controller/status bytes that carry no keystroke when seen outside a prefix.
  always_comb begin
    w_noise = 1'b0;
    case (ps2_out)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_noise = 1'b1;
      default:                                 w_noise = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = {2'b00, ps2_out};
    if (ps2_key_pressed) begin
      case (r_state)
        IDLE: begin
          if (ps2_out == c_ext_pfx)      w_state_nxt = EXT;
          else if (ps2_out == c_brk_pfx) w_state_nxt = BRK;
          else if (!w_noise)             w_push = 1'b1;
        end
        EXT: begin
          if (ps2_out == c_brk_pfx)      w_state_nxt = EXTBRK;
          else if (ps2_out != c_ext_pfx) begin
            w_push      = 1'b1;
            w_push_data = {2'b01, ps2_out};
            w_state_nxt = IDLE;
          end
        end
        BRK: begin
          if (ps2_out == c_ext_pfx)      w_state_nxt = EXTBRK;
          else if (ps2_out != c_brk_pfx) begin
            w_push      = 1'b1;
            w_push_data = {2'b10, ps2_out};
            w_state_nxt = IDLE;
          end
        end
        EXTBRK: begin
          if (ps2_out != c_ext_pfx && ps2_out != c_brk_pfx) begin
            w_push      = 1'b1;
            w_push_data = {2'b11, ps2_out};
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
  assign w_full      = (r_count == c_depth);
  assign w_pop       = rd_en & r_valid;
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_ovf_set   = w_push & w_full & ~w_pop;
  assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, w_wr} - {{ADDR_W{1'b0}}, w_pop};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_ovf_set)           r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign key_valid = r_valid;
  assign key_data  = r_valid ? {22'd0, r_mem[r_rd_ptr]} : 32'd0;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/ps2_key_buffer.md
Name: ps2_key_buffer

Overview:
- Sits upstream of the processor's keyboard input path.
- Takes raw PS/2 scancode bytes, strobed one per cycle, and decodes E0 (extended) and F0 (break) prefixes into single key events.
- Buffers the events in a first-word-fall-through FIFO.
- The processor pops one 32-bit key word per read, so no keystroke is lost while the pipeline is stalled.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3: log2(DEPTH); FIFO pointer width.

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- ps2_key_pressed  input  1  one-cycle strobe: ps2_out holds a new byte this cycle
- ps2_out  input  8  raw scancode byte from the PS/2 receiver
- rd_en  input  1  processor pop request; ignored when key_valid=0
- clear_overflow  input  1  clears the sticky overflow flag
- key_valid  output  1  FIFO non-empty; key_data is meaningful
- key_data  output  32  head entry: [7:0] code, [8] extended, [9] break, [31:10] zero
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH
- overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - FSM to IDLE; read and write pointers to 0; count=0.
  - key_valid=0, key_data=0, overflow=0.
  - A reset mid-sequence (e.g. after E0) discards the partial prefix.
- Prefix FSM advances only in cycles with ps2_key_pressed=1. States: IDLE, EXT, BRK, EXTBRK.
  - IDLE:
    - 0xE0 goes to EXT; 0xF0 goes to BRK.
    - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF are dropped (no push, stay IDLE).
    - Any other byte pushes {ext=0, brk=0, code}.
  - EXT:
    - 0xF0 goes to EXTBRK; 0xE0 stays EXT.
    - Any other byte pushes {ext=1, brk=0}, then returns to IDLE.
  - BRK:
    - 0xE0 goes to EXTBRK; 0xF0 stays BRK.
    - Any other byte pushes {ext=0, brk=1}, then returns to IDLE.
  - EXTBRK:
    - 0xE0 or 0xF0 stays EXTBRK.
    - Any other byte pushes {ext=1, brk=1}, then returns to IDLE.
- FIFO:
  - A push is written on the edge where the data byte is strobed.
  - key_valid and the new head appear the following cycle (1-cycle latency when the FIFO was empty).
  - First-word fall-through: key_data always shows the head entry combinationally from storage; when empty it shows 0.
  - A pop (rd_en=1 and key_valid=1) advances the read pointer at the edge; the next entry is visible the next cycle.
- Boundary conditions:
  - Pointers wrap modulo DEPTH.
  - count updates as count + push - pop.
  - Push while full with no pop: the event is discarded, storage is unchanged, overflow is set to 1.
  - Push and pop in the same cycle while full: both happen, count stays DEPTH, no overflow.
  - Push and pop in the same cycle while empty: push happens, the pop is ignored, count becomes 1.
  - rd_en while empty: no effect.
  - clear_overflow and a new overflow in the same cycle: overflow stays 1 (set wins).
- All outputs are registered except key_data, which is a combinational read of registered storage.

Test Plan:
- Reset, then strobe 0x1C -> next cycle key_valid=1, key_data=0x0000001C, count=1; rd_en one cycle -> key_valid=0, count=0.
- Strobe sequence F0,1C -> exactly one entry, key_data=0x0000021C; strobe sequence E0,F0,75 -> key_data=0x00000375.
- Strobe 0xAA, then 0xFA, in IDLE -> count stays 0; strobe E0 then assert reset, release, strobe 6B -> key_data=0x0000006B (prefix discarded).
- Push 9 make codes 0x01..0x09 with DEPTH=8 -> count=8, overflow=1; pop 8 times -> codes 0x01..0x08 in order; pulse clear_overflow -> overflow=0.
- FIFO full plus simultaneous strobe 0x22 and rd_en -> count stays 8, overflow stays 0, 0x22 is the last entry popped.
- FIFO empty plus simultaneous strobe 0x15 and rd_en -> count=1, key_data=0x00000015 next cycle; 20 push/pop cycles across pointer wrap -> order preserved.
